// File: rtl/reg_file_sb_if.sv
// Bus bundle for the scoreboarded register file: two read ports, one
// writeback port, one issue port and the busy count.
//   master: drives addresses, writeback and issue; receives data/busy/count
//   slave : the register file itself
interface reg_file_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              readBusy1;
  logic              readBusy2;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic [ADDR_W-1:0] issueReg;
  logic              issueValid;
  logic [ADDR_W:0]   busyCount;

  modport master (
    output readReg1, readReg2, writeReg, writeData, regWrite, issueReg, issueValid,
    input  readData1, readData2, readBusy1, readBusy2, busyCount
  );

  modport slave (
    input  readReg1, readReg2, writeReg, writeData, regWrite, issueReg, issueValid,
    output readData1, readData2, readBusy1, readBusy2, busyCount
  );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised register file with per-register busy scoreboard.
//   clk   : clock, all state changes on rising edge
//   rst_n : synchronous active-low reset (clears data, busy bits, count)
//   bus   : reg_file_sb_if.slave -- two combinational read ports with busy
//           flags, writeback port, issue port, registered busyCount
// ZERO_REG=1 hardwires register 0 to zero; BYPASS=1 forwards a same-cycle
// writeback to the read ports and masks the matching busy flag.
module reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;
  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     countNext;
  logic                writeEn;
  logic                issueEn;
  logic                setOne;
  logic                clrOne;
  logic                hit1;
  logic                hit2;
  logic                zero1;
  logic                zero2;

  // Writes/issues to a hardwired R0 are dropped before they reach state.
  always_comb begin
    writeEn = bus.regWrite;
    issueEn = bus.issueValid;
    if (ZERO_REG != 0) begin
      if (bus.writeReg == '0) writeEn = 1'b0;
      if (bus.issueReg == '0) issueEn = 1'b0;
    end
  end

  // Issue is applied after writeback so a new producer wins the same register.
  // The count moves by the real transitions only, keeping it equal to the
  // popcount of busy without a popcount tree.
  always_comb begin
    busyNext = busy;
    if (writeEn) busyNext[bus.writeReg] = 1'b0;
    if (issueEn) busyNext[bus.issueReg] = 1'b1;
    setOne    = issueEn && !busy[bus.issueReg];
    clrOne    = writeEn && busy[bus.writeReg] &&
                !(issueEn && (bus.issueReg == bus.writeReg));
    countNext = count + (ADDR_W+1)'(setOne) - (ADDR_W+1)'(clrOne);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy  <= '0;
      count <= '0;
    end else begin
      if (writeEn) regs[bus.writeReg] <= bus.writeData;
      busy  <= busyNext;
      count <= countNext;
    end
  end

  always_comb begin
    zero1 = (ZERO_REG != 0) && (bus.readReg1 == '0);
    zero2 = (ZERO_REG != 0) && (bus.readReg2 == '0);
    hit1  = (BYPASS != 0) && writeEn && (bus.writeReg == bus.readReg1);
    hit2  = (BYPASS != 0) && writeEn && (bus.writeReg == bus.readReg2);

    if (zero1)     bus.readData1 = '0;
    else if (hit1) bus.readData1 = bus.writeData;
    else           bus.readData1 = regs[bus.readReg1];

    if (zero2)     bus.readData2 = '0;
    else if (hit2) bus.readData2 = bus.writeData;
    else           bus.readData2 = regs[bus.readReg2];

    bus.readBusy1 = !zero1 && !hit1 && busy[bus.readReg1];
    bus.readBusy2 = !zero2 && !hit2 && busy[bus.readReg2];
    bus.busyCount = count;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rstA = 1'b0;
  logic rstB = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(8), .ADDR_W(3)) busA ();
  reg_file_sb_if #(.DATA_W(8), .ADDR_W(3)) busB ();

  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clk(clk), .rst_n(rstA), .bus(busA)
  );
  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk(clk), .rst_n(rstB), .bus(busB)
  );

  typedef struct {
    logic       rstn;
    logic [2:0] rr1, rr2, wr;
    logic [7:0] wd;
    logic       we;
    logic [2:0] ir;
    logic       iv;
    logic [7:0] rd1, rd2;
    logic       rb1, rb2;
    logic [3:0] bc;
  } vec_t;

  vec_t vecs[$];

  task automatic addV(input logic rstn, input logic [2:0] rr1, input logic [2:0] rr2,
                      input logic we, input logic [2:0] wr, input logic [7:0] wd,
                      input logic iv, input logic [2:0] ir,
                      input logic [7:0] rd1, input logic [7:0] rd2,
                      input logic rb1, input logic rb2, input logic [3:0] bc);
    vec_t v;
    v.rstn = rstn; v.rr1 = rr1; v.rr2 = rr2; v.we = we; v.wr = wr; v.wd = wd;
    v.iv = iv; v.ir = ir; v.rd1 = rd1; v.rd2 = rd2; v.rb1 = rb1; v.rb2 = rb2; v.bc = bc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idleA();
    busA.readReg1 = '0; busA.readReg2 = '0; busA.writeReg = '0; busA.writeData = '0;
    busA.regWrite = 1'b0; busA.issueReg = '0; busA.issueValid = 1'b0;
  endtask

  task automatic idleB();
    busB.readReg1 = '0; busB.readReg2 = '0; busB.writeReg = '0; busB.writeData = '0;
    busB.regWrite = 1'b0; busB.issueReg = '0; busB.issueValid = 1'b0;
  endtask

  // Inputs are applied after an edge, outputs compared 1ns later (before the
  // next edge), then one clock is consumed.
  task automatic applyA(input vec_t v, input int idx);
    rstA = v.rstn;
    busA.readReg1 = v.rr1; busA.readReg2 = v.rr2;
    busA.regWrite = v.we;  busA.writeReg = v.wr; busA.writeData = v.wd;
    busA.issueValid = v.iv; busA.issueReg = v.ir;
    #1;
    chk("A.readData1", idx, 32'(busA.readData1), 32'(v.rd1));
    chk("A.readData2", idx, 32'(busA.readData2), 32'(v.rd2));
    chk("A.readBusy1", idx, 32'(busA.readBusy1), 32'(v.rb1));
    chk("A.readBusy2", idx, 32'(busA.readBusy2), 32'(v.rb2));
    chk("A.busyCount", idx, 32'(busA.busyCount), 32'(v.bc));
    @(posedge clk); #1;
  endtask

  task automatic stepB(input int idx, input logic [2:0] rr, input logic we,
                       input logic [2:0] wr, input logic [7:0] wd,
                       input logic iv, input logic [2:0] ir,
                       input logic [7:0] rd, input logic rb, input logic [3:0] bc);
    busB.readReg1 = rr; busB.readReg2 = rr;
    busB.regWrite = we; busB.writeReg = wr; busB.writeData = wd;
    busB.issueValid = iv; busB.issueReg = ir;
    #1;
    chk("B.readData1", idx, 32'(busB.readData1), 32'(rd));
    chk("B.readData2", idx, 32'(busB.readData2), 32'(rd));
    chk("B.readBusy1", idx, 32'(busB.readBusy1), 32'(rb));
    chk("B.readBusy2", idx, 32'(busB.readBusy2), 32'(rb));
    chk("B.busyCount", idx, 32'(busB.busyCount), 32'(bc));
    @(posedge clk); #1;
  endtask

  initial begin
    idleA();
    idleB();
    rstA = 1'b0;
    rstB = 1'b0;

    //   rstn rr1 rr2 we wr wd     iv ir  rd1    rd2    rb1 rb2 bc
    addV(1, 3, 3, 1, 3, 8'hA5, 0, 0, 8'hA5, 8'hA5, 0, 0, 0); // bypass, both ports same reg
    addV(1, 3, 0, 0, 0, 8'h00, 0, 0, 8'hA5, 8'h00, 0, 0, 0); // stored value
    addV(1, 0, 0, 1, 0, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 0); // R0 write+issue ignored
    addV(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    addV(1, 0, 5, 0, 0, 8'h00, 1, 5, 8'h00, 8'h00, 0, 0, 0); // issue R5
    addV(1, 5, 5, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 1);
    addV(1, 3, 5, 1, 5, 8'h3C, 0, 0, 8'hA5, 8'h3C, 0, 0, 1); // writeback R5, masked
    addV(1, 0, 5, 0, 0, 8'h00, 0, 0, 8'h00, 8'h3C, 0, 0, 0);
    addV(1, 2, 0, 0, 0, 8'h00, 1, 2, 8'h00, 8'h00, 0, 0, 0); // issue R2
    addV(1, 2, 0, 1, 2, 8'h11, 1, 2, 8'h11, 8'h00, 0, 0, 1); // issue+wb same reg
    addV(1, 2, 0, 0, 0, 8'h00, 0, 0, 8'h11, 8'h00, 1, 0, 1); // stays busy, data written
    addV(1, 2, 0, 1, 2, 8'h22, 0, 0, 8'h22, 8'h00, 0, 0, 1); // clear R2
    addV(1, 2, 0, 0, 0, 8'h00, 0, 0, 8'h22, 8'h00, 0, 0, 0);
    addV(1, 0, 0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 0, 0, 0); // issue R1
    addV(1, 0, 0, 0, 0, 8'h00, 1, 2, 8'h00, 8'h00, 0, 0, 1); // issue R2
    addV(1, 4, 0, 0, 0, 8'h00, 1, 4, 8'h00, 8'h00, 0, 0, 2); // issue R4
    addV(1, 4, 1, 1, 1, 8'h44, 1, 4, 8'h00, 8'h44, 1, 0, 3); // reissue busy R4, wb R1
    addV(1, 1, 4, 0, 0, 8'h00, 0, 0, 8'h44, 8'h00, 0, 1, 2);
    addV(1, 6, 2, 1, 2, 8'h55, 1, 6, 8'h00, 8'h55, 0, 0, 2); // set+clear, net 0
    addV(1, 6, 2, 0, 0, 8'h00, 0, 0, 8'h00, 8'h55, 1, 0, 2);
    addV(0, 6, 2, 1, 4, 8'h77, 0, 0, 8'h00, 8'h55, 1, 0, 2); // reset with write pending
    addV(1, 4, 6, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    addV(1, 2, 3, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    rstA = 1'b1;
    rstB = 1'b1;

    // Reset state of both instances.
    busA.readReg1 = 3'd3; busA.readReg2 = 3'd5;
    busB.readReg1 = 3'd6; busB.readReg2 = 3'd0;
    #1;
    chk("rst.A.readData1", 0, 32'(busA.readData1), 32'h0);
    chk("rst.A.readBusy2", 0, 32'(busA.readBusy2), 32'h0);
    chk("rst.A.busyCount", 0, 32'(busA.busyCount), 32'h0);
    chk("rst.B.readData1", 0, 32'(busB.readData1), 32'h0);
    chk("rst.B.busyCount", 0, 32'(busB.busyCount), 32'h0);

    foreach (vecs[i]) applyA(vecs[i], i);
    idleA();
    rstA = 1'b1;

    // No bypass, ordinary R0.
    //    idx rr we wr wd     iv ir rd     rb bc
    stepB(0, 6, 1, 6, 8'h9E, 0, 0, 8'h00, 0, 0); // old value while writing
    stepB(1, 6, 0, 0, 8'h00, 1, 6, 8'h9E, 0, 0); // written; issue R6
    stepB(2, 6, 1, 6, 8'hAA, 1, 6, 8'h9E, 1, 1); // issue+wb: busy not masked
    stepB(3, 6, 0, 0, 8'h00, 0, 0, 8'hAA, 1, 1);
    stepB(4, 0, 1, 0, 8'h12, 0, 0, 8'h00, 0, 1); // R0 is a real register
    stepB(5, 0, 1, 6, 8'hBB, 0, 0, 8'h12, 0, 1);
    stepB(6, 6, 0, 0, 8'h00, 0, 0, 8'hBB, 0, 0);
    idleB();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised, scoreboarded register file for the 8-bit CPU datapath; next generation of the current 8x8 register file.
- Provides two asynchronous read ports and one write (writeback) port, with generic width and depth.
- Adds optional hardwired-zero R0, write-to-read bypass, synchronous clear, and a per-register busy scoreboard.
- The scoreboard lets decode stall on registers with an outstanding writeback.

Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, register address width; register count is NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 always reads 0, and writes/issues to it are ignored; 0 = register 0 is ordinary
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- readReg1  in  ADDR_W  read port 1 address
- readReg2  in  ADDR_W  read port 2 address
- readData1  out  DATA_W  read port 1 data (combinational)
- readData2  out  DATA_W  read port 2 data (combinational)
- readBusy1  out  1  register at readReg1 has a pending writeback
- readBusy2  out  1  register at readReg2 has a pending writeback
- writeReg  in  ADDR_W  writeback address
- writeData  in  DATA_W  writeback data
- regWrite  in  1  writeback enable
- issueReg  in  ADDR_W  destination of a newly issued instruction
- issueValid  in  1  mark issueReg busy
- busyCount  out  ADDR_W+1  number of busy registers

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - All registers cleared to 0; all busy bits cleared; busyCount = 0.
  - regWrite and issueValid are ignored in that cycle.
  - Reset asserted mid-operation discards any pending busy state with no residue.
- Write: on the rising edge with rst_n=1 and regWrite=1, registers[writeReg] <= writeData. Write-to-storage latency is 1 cycle.
- ZERO_REG=1:
  - readRegN==0 yields readDataN=0 and readBusyN=0.
  - regWrite to 0 does not modify storage; issueValid to 0 does not set busy.
- Read data (combinational, 0-cycle latency):
  - BYPASS=1 and regWrite=1 and writeReg==readRegN (and not zero-reg) yields readDataN=writeData.
  - Otherwise readDataN = registers[readRegN].
  - Both ports may address the same register and must return identical data.
- Scoreboard, per register r, next-state of busy[r]:
  - Set if issueValid and issueReg==r.
  - Else cleared if regWrite and writeReg==r.
  - Else held.
  - Simultaneous issue and writeback to the same r leaves busy[r]=1: the new producer wins; the data is still written.
  - Issue to an already-busy register keeps it busy (no count change).
  - Writeback to a non-busy register writes data; busy stays 0.
- readBusyN:
  - busy[readRegN], except when BYPASS=1, regWrite=1 and writeReg==readRegN, where it reads 0 (the writeback satisfies the dependency this cycle).
  - With BYPASS=0, readBusyN = busy[readRegN] without masking.
- busyCount:
  - Registered; equals the popcount of the busy vector after each edge.
  - Updated incrementally: +1 on set of a non-busy register, -1 on clear of a busy register, net 0 when both occur on different registers in the same cycle.
  - Range 0..NUM_REGS (NUM_REGS-1 when ZERO_REG=1); never wraps.
- Storage contents are never X after reset; no reset of contents on any other condition.

Test Plan:
- Reset, then write 0xA5 to R3 at edge 1; read R3 on port 1 at cycle 2 -> readData1=0xA5. Before that edge, with BYPASS=1, readData1=0xA5 already in the write cycle.
- ZERO_REG=1: write 0xFF to R0 and issue R0 -> readData1=0x00, readBusy1=0, busyCount=0.
- Issue R5 -> next cycle readBusy2=1 at readReg2=5, busyCount=1. Writeback R5=0x3C -> same cycle readBusy2=0 and readData2=0x3C (bypass); next cycle busyCount=0.
- Same cycle: issue R2 and writeback R2=0x11 with R2 previously busy -> R2 stays busy, storage=0x11, busyCount unchanged (1).
- Issue R1, R2, R4 on successive cycles (busyCount 1,2,3). Then assert rst_n=0 with regWrite=1 to R4=0x77 -> busyCount=0, all busy 0, R4 reads 0x00.
- BYPASS=0: write R6=0x9E while reading R6 -> readData=old value 0x00 that cycle, 0x9E next cycle. Issue/writeback of R6 in the same cycle gives readBusy=1 that cycle.
